// File: rtl/stream_unpacker.sv
// Unpacks 24bpp AXI4-Stream video (4 pixels per 3 words) into one RGB pixel per handshake,
// tracks pixel coordinates and flags/resynchronises on tuser/tlast framing errors.
module stream_unpacker #(
  parameter int unsigned X_SIZE = 640,
  parameter int unsigned Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        sof_err,
  output logic        eol_err
);

  localparam int unsigned WordsPerLine = 3 * X_SIZE / 4;
  localparam logic [9:0]  XLast  = 10'(X_SIZE - 1);
  localparam logic [8:0]  YLast  = 9'(Y_SIZE - 1);
  localparam logic [9:0]  WxLast = 10'(WordsPerLine - 1);

  logic        run_q;
  logic [1:0]  r_q, r_d;
  logic [23:0] res_q, res_d;
  logic [23:0] pix_q, pix_d;
  logic        pv_q, pv_d;
  logic [9:0]  px_q, px_d, nx_q, nx_d, wx_q, wx_d;
  logic [8:0]  py_q, py_d, ny_q, ny_d, wy_q, wy_d;
  logic        psof_q, psof_d, peol_q, peol_d;
  logic        sof_err_q, sof_err_d, eol_err_q, eol_err_d;

  logic        out_free, accept, restart, last_exp, load, early;
  logic [1:0]  r_eff;
  logic [9:0]  wx_eff, cx;
  logic [8:0]  wy_eff, cy;
  logic [23:0] ld_pix;

  // run_q keeps tready low until the first edge after reset release.
  assign out_free         = !pv_q | pix_ready;
  assign in_stream_tready = run_q & (r_q != 2'd3) & out_free;
  assign accept           = in_stream_tvalid & in_stream_tready;
  assign restart          = accept & in_stream_tuser & !((wx_q == '0) && (wy_q == '0));

  always_comb begin
    r_d       = r_q;
    res_d     = res_q;
    pix_d     = pix_q;
    pv_d      = pv_q;
    px_d      = px_q;
    py_d      = py_q;
    nx_d      = nx_q;
    ny_d      = ny_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    psof_d    = psof_q;
    peol_d    = peol_q;
    sof_err_d = 1'b0;
    eol_err_d = 1'b0;
    load      = 1'b0;
    ld_pix    = res_q;
    // A misplaced tuser restarts the frame before any tlast rule is evaluated.
    r_eff     = restart ? 2'd0 : r_q;
    wx_eff    = restart ? 10'd0 : wx_q;
    wy_eff    = restart ? 9'd0 : wy_q;
    cx        = restart ? 10'd0 : nx_q;
    cy        = restart ? 9'd0 : ny_q;
    last_exp  = (wx_eff == WxLast);
    early     = accept & in_stream_tlast & !last_exp;

    if (accept) begin
      load = 1'b1;
      case (r_eff)
        2'd0: begin
          ld_pix = in_stream_tdata[23:0];
          res_d  = {16'h0, in_stream_tdata[31:24]};
          r_d    = 2'd1;
        end
        2'd1: begin
          ld_pix = {in_stream_tdata[15:0], res_q[7:0]};
          res_d  = {8'h0, in_stream_tdata[31:16]};
          r_d    = 2'd2;
        end
        default: begin
          ld_pix = {in_stream_tdata[7:0], res_q[15:0]};
          res_d  = in_stream_tdata[31:8];
          r_d    = 2'd3;
        end
      endcase
      if (in_stream_tlast || last_exp) begin
        wx_d = 10'd0;
        wy_d = (wy_eff == YLast) ? 9'd0 : wy_eff + 9'd1;
      end else begin
        wx_d = wx_eff + 10'd1;
        wy_d = wy_eff;
      end
      eol_err_d = in_stream_tlast ^ last_exp;
      sof_err_d = restart;
    end else if (run_q && out_free) begin
      if (r_q == 2'd3) begin
        load   = 1'b1;
        ld_pix = res_q;
        r_d    = 2'd0;
      end else begin
        pv_d = 1'b0;
      end
    end

    if (load) begin
      pix_d  = ld_pix;
      pv_d   = 1'b1;
      px_d   = cx;
      py_d   = cy;
      psof_d = (cx == '0) && (cy == '0);
      peol_d = (cx == XLast);
      if (cx == XLast || early) begin
        nx_d = 10'd0;
        ny_d = (cy == YLast) ? 9'd0 : cy + 9'd1;
      end else begin
        nx_d = cx + 10'd1;
        ny_d = cy;
      end
      if (early) begin
        r_d   = 2'd0;
        res_d = '0;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q     <= 1'b0;
      r_q       <= '0;
      res_q     <= '0;
      pix_q     <= '0;
      pv_q      <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      nx_q      <= '0;
      ny_q      <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      psof_q    <= 1'b0;
      peol_q    <= 1'b0;
      sof_err_q <= 1'b0;
      eol_err_q <= 1'b0;
    end else begin
      run_q     <= 1'b1;
      r_q       <= r_d;
      res_q     <= res_d;
      pix_q     <= pix_d;
      pv_q      <= pv_d;
      px_q      <= px_d;
      py_q      <= py_d;
      nx_q      <= nx_d;
      ny_q      <= ny_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      psof_q    <= psof_d;
      peol_q    <= peol_d;
      sof_err_q <= sof_err_d;
      eol_err_q <= eol_err_d;
    end
  end

  assign pix_r     = pix_q[23:16];
  assign pix_g     = pix_q[15:8];
  assign pix_b     = pix_q[7:0];
  assign pix_x     = px_q;
  assign pix_y     = py_q;
  assign pix_sof   = psof_q;
  assign pix_eol   = peol_q;
  assign pix_valid = pv_q;
  assign sof_err   = sof_err_q;
  assign eol_err   = eol_err_q;

  logic unused_keep;
  assign unused_keep = ^in_stream_tkeep;

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed table of single-cycle vectors plus reset and two-frame randomised handshake sequences
// for stream_unpacker on an 8x4 frame.
module tb_stream_unpacker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] in_tdata = '0;
  logic        in_tlast = 1'b0, in_tuser = 1'b0, in_tvalid = 1'b0, in_tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid, sof_err, eol_err;
  logic        pix_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  stream_unpacker #(.X_SIZE(8), .Y_SIZE(4)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .in_stream_tdata  (in_tdata),
    .in_stream_tkeep  (4'hF),
    .in_stream_tlast  (in_tlast),
    .in_stream_tuser  (in_tuser),
    .in_stream_tvalid (in_tvalid),
    .in_stream_tready (in_tready),
    .pix_r            (pix_r),
    .pix_g            (pix_g),
    .pix_b            (pix_b),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_sof          (pix_sof),
    .pix_eol          (pix_eol),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .sof_err          (sof_err),
    .eol_err          (eol_err)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] d;
    logic        u, l, v, pr;
    logic        trdy, pv;
    logic [23:0] pix;
    int          x, y;
    logic        sof, eol, serr, lerr;
  } vec_t;

  vec_t vt[28];

  function automatic vec_t mk(logic [31:0] d, logic u, logic l, logic v, logic pr, logic trdy,
                              logic pv, logic [23:0] pix, int x, int y, logic sof, logic eol,
                              logic serr, logic lerr);
    vec_t r;
    r.d = d; r.u = u; r.l = l; r.v = v; r.pr = pr; r.trdy = trdy; r.pv = pv; r.pix = pix;
    r.x = x; r.y = y; r.sof = sof; r.eol = eol; r.serr = serr; r.lerr = lerr;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bt(int k);
    return 8'(k);
  endfunction

  task automatic pulse_reset();
    aresetn   = 1'b0;
    in_tvalid = 1'b0;
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int j, p, cyc, err_seen, px, py;
    logic [23:0] epix;

    //  data        u  l  v  pr  trdy pv pix      x  y  sof eol serr lerr
    vt[0]  = mk(32'h44332211, 1, 0, 1, 1, 1, 1, 24'h332211, 0, 0, 1, 0, 0, 0);
    vt[1]  = mk(32'h88776655, 0, 0, 1, 1, 1, 1, 24'h665544, 1, 0, 0, 0, 0, 0);
    vt[2]  = mk(32'hCCBBAA99, 0, 0, 1, 1, 1, 1, 24'h998877, 2, 0, 0, 0, 0, 0);
    vt[3]  = mk(32'h04030201, 0, 0, 1, 1, 0, 1, 24'hCCBBAA, 3, 0, 0, 0, 0, 0);
    vt[4]  = mk(32'h04030201, 0, 0, 1, 1, 1, 1, 24'h030201, 4, 0, 0, 0, 0, 0);
    vt[5]  = mk(32'h08070605, 0, 0, 1, 1, 1, 1, 24'h060504, 5, 0, 0, 0, 0, 0);
    vt[6]  = mk(32'h0C0B0A09, 0, 1, 1, 1, 1, 1, 24'h090807, 6, 0, 0, 0, 0, 0);
    vt[7]  = mk(32'h14131211, 0, 0, 1, 1, 0, 1, 24'h0C0B0A, 7, 0, 0, 1, 0, 0);
    vt[8]  = mk(32'h14131211, 0, 0, 1, 1, 1, 1, 24'h131211, 0, 1, 0, 0, 0, 0);
    for (int i = 9; i <= 13; i++)
      vt[i] = mk(32'h18171615, 0, 0, 1, 0, 0, 1, 24'h131211, 0, 1, 0, 0, 0, 0);
    vt[14] = mk(32'h18171615, 0, 0, 1, 1, 1, 1, 24'h161514, 1, 1, 0, 0, 0, 0);
    vt[15] = mk(32'h1C1B1A19, 0, 1, 1, 1, 1, 1, 24'h191817, 2, 1, 0, 0, 0, 1);
    vt[16] = mk(32'h24232221, 0, 0, 1, 1, 1, 1, 24'h232221, 0, 2, 0, 0, 0, 0);
    vt[17] = mk(32'h28272625, 1, 0, 1, 1, 1, 1, 24'h272625, 0, 0, 1, 0, 1, 0);
    vt[18] = mk(32'h2C2B2A29, 0, 0, 1, 1, 1, 1, 24'h2A2928, 1, 0, 0, 0, 0, 0);
    vt[19] = mk(32'h302F2E2D, 0, 0, 1, 1, 1, 1, 24'h2D2C2B, 2, 0, 0, 0, 0, 0);
    vt[20] = mk(32'h34333231, 0, 0, 1, 1, 0, 1, 24'h302F2E, 3, 0, 0, 0, 0, 0);
    vt[21] = mk(32'h34333231, 0, 0, 1, 1, 1, 1, 24'h333231, 4, 0, 0, 0, 0, 0);
    vt[22] = mk(32'h38373635, 0, 0, 1, 1, 1, 1, 24'h363534, 5, 0, 0, 0, 0, 0);
    vt[23] = mk(32'h3C3B3A39, 0, 0, 1, 1, 1, 1, 24'h393837, 6, 0, 0, 0, 0, 1);
    vt[24] = mk(32'h44434241, 0, 0, 1, 1, 0, 1, 24'h3C3B3A, 7, 0, 0, 1, 0, 0);
    vt[25] = mk(32'h44434241, 0, 0, 1, 1, 1, 1, 24'h434241, 0, 1, 0, 0, 0, 0);
    vt[26] = mk(32'h48474645, 0, 0, 0, 1, 1, 0, 24'h000000, 0, 0, 0, 0, 0, 0);
    vt[27] = mk(32'h48474645, 0, 0, 1, 1, 1, 1, 24'h464544, 1, 1, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", 32'(in_tready), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_pix", {8'h0, pix_r, pix_g, pix_b}, 0);
    chk("rst_xy", {13'h0, pix_y, pix_x}, 0);
    chk("rst_flags", {28'h0, pix_sof, pix_eol, sof_err, eol_err}, 0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("first_tready", 32'(in_tready), 1);

    foreach (vt[i]) begin
      in_tdata  = vt[i].d;
      in_tuser  = vt[i].u;
      in_tlast  = vt[i].l;
      in_tvalid = vt[i].v;
      pix_ready = vt[i].pr;
      #1;
      chk($sformatf("v%0d_tready", i), 32'(in_tready), 32'(vt[i].trdy));
      @(posedge aclk);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(pix_valid), 32'(vt[i].pv));
      if (vt[i].pv) begin
        chk($sformatf("v%0d_pix", i), {8'h0, pix_r, pix_g, pix_b}, 32'(vt[i].pix));
        chk($sformatf("v%0d_x", i), 32'(pix_x), vt[i].x);
        chk($sformatf("v%0d_y", i), 32'(pix_y), vt[i].y);
        chk($sformatf("v%0d_sof_eol", i), {30'h0, pix_sof, pix_eol},
            {30'h0, vt[i].sof, vt[i].eol});
      end
      chk($sformatf("v%0d_errs", i), {30'h0, sof_err, eol_err}, {30'h0, vt[i].serr, vt[i].lerr});
    end

    // Reset mid-line with two residue bytes held
    in_tvalid = 1'b0;
    #3 aresetn = 1'b0;
    #1;
    chk("mid_rst_tready", 32'(in_tready), 0);
    chk("mid_rst_valid", 32'(pix_valid), 0);
    chk("mid_rst_pix", {8'h0, pix_r, pix_g, pix_b}, 0);
    chk("mid_rst_xy", {13'h0, pix_y, pix_x}, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_tready", 32'(in_tready), 1);
    in_tdata  = 32'h54535251;
    in_tuser  = 1'b1;
    in_tlast  = 1'b0;
    in_tvalid = 1'b1;
    pix_ready = 1'b1;
    @(posedge aclk);
    #1;
    chk("post_rst_pix", {8'h0, pix_r, pix_g, pix_b}, 32'h535251);
    chk("post_rst_xy", {13'h0, pix_y, pix_x}, 0);
    chk("post_rst_sof", 32'(pix_sof), 1);
    chk("post_rst_errs", {30'h0, sof_err, eol_err}, 0);

    // Two clean frames with random tvalid/pix_ready
    pulse_reset();
    j = 0; p = 0; cyc = 0; err_seen = 0;
    while (p < 64 && cyc < 3000) begin
      in_tvalid = ($urandom_range(0, 3) != 0) && (j < 48);
      in_tdata  = {bt(4*j+3), bt(4*j+2), bt(4*j+1), bt(4*j)};
      in_tuser  = (j % 24 == 0);
      in_tlast  = (j % 6 == 5);
      pix_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (pix_valid && pix_ready) begin
        epix = {bt(3*p+2), bt(3*p+1), bt(3*p)};
        px = p % 8;
        py = (p / 8) % 4;
        chk($sformatf("frm_p%0d_pix", p), {8'h0, pix_r, pix_g, pix_b}, 32'(epix));
        chk($sformatf("frm_p%0d_xy", p), {13'h0, pix_y, pix_x}, 32'((py << 10) | px));
        chk($sformatf("frm_p%0d_sof_eol", p), {30'h0, pix_sof, pix_eol},
            {30'h0, (px == 0 && py == 0), (px == 7)});
        p++;
      end
      if (in_tvalid && in_tready) j++;
      if (sof_err || eol_err) err_seen++;
      @(posedge aclk);
      #1;
      cyc++;
    end
    chk("frm_pixel_count", p, 64);
    chk("frm_word_count", j, 48);
    chk("frm_err_pulses", err_seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
